// File: rtl/dly_line_pkg.sv
// Shared defaults and width helper for the dly_line delay-line / one-shot block.
package dly_line_pkg;

    localparam int unsigned DEF_TAPS    = 11;
    localparam int unsigned DEF_TAP_CYC = 1;
    localparam int unsigned DEF_CH      = 2;
    localparam int unsigned DEF_PW_CYC  = 2;

    // Counter width able to hold the value pw (pw itself, not pw-1).
    function automatic int unsigned cnt_w(input int unsigned pw);
        return $clog2(pw + 1);
    endfunction

endpackage

// File: rtl/dly_oneshot.sv
// Falling-edge one-shot: emits a PW_CYC-clock pulse, retriggerable when RETRIG is nonzero.
module dly_oneshot
    import dly_line_pkg::*;
#(
    parameter int unsigned PW_CYC = DEF_PW_CYC,
    parameter int unsigned RETRIG = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic trig,
    output logic pulse
);

    localparam int unsigned CNT_W = cnt_w(PW_CYC);

    logic             prev_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             fall;

    always_comb begin
        fall  = prev_q & ~trig;
        cnt_d = cnt_q;
        // Non-retriggerable channels only accept an edge on the last pulse cycle or when idle.
        if (fall && ((RETRIG != 0) || (cnt_q <= CNT_W'(1)))) begin
            cnt_d = CNT_W'(PW_CYC);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            prev_q <= trig;
            cnt_q  <= cnt_d;
        end
    end

    assign pulse = (cnt_q != '0);

endmodule

// File: rtl/dly_line.sv
// Tapped delay line with CH falling-edge one-shots.
// Optional macro DLY_LINE_IN_SYNC_EN adds two-flop input synchronisers (+2 clocks latency).
module dly_line
    import dly_line_pkg::*;
#(
    parameter int unsigned TAPS    = DEF_TAPS,
    parameter int unsigned TAP_CYC = DEF_TAP_CYC,
    parameter int unsigned CH      = DEF_CH,
    parameter int unsigned PW_CYC  = DEF_PW_CYC,
    parameter int unsigned RETRIG  = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            din,
    output logic [TAPS-1:0] taps,
    input  logic [CH-1:0]   trig,
    output logic [CH-1:0]   pulse
);

    localparam int unsigned STAGES = TAPS * TAP_CYC;

    logic          din_s;
    logic [CH-1:0] trig_s;

`ifdef DLY_LINE_IN_SYNC_EN
    logic          din_meta_q;
    logic          din_sync_q;
    logic [CH-1:0] trig_meta_q;
    logic [CH-1:0] trig_sync_q;

    // Synchronisers reset to the inactive (high) level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            din_meta_q  <= 1'b1;
            din_sync_q  <= 1'b1;
            trig_meta_q <= '1;
            trig_sync_q <= '1;
        end else begin
            din_meta_q  <= din;
            din_sync_q  <= din_meta_q;
            trig_meta_q <= trig;
            trig_sync_q <= trig_meta_q;
        end
    end

    assign din_s  = din_sync_q;
    assign trig_s = trig_sync_q;
`else
    assign din_s  = din;
    assign trig_s = trig;
`endif

    logic [STAGES-1:0] sr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q <= '0;
        end else begin
            sr_q[0] <= ~din_s;
            for (int i = 1; i < STAGES; i++) begin
                sr_q[i] <= sr_q[i-1];
            end
        end
    end

    for (genvar k = 0; k < TAPS; k++) begin : g_tap
        assign taps[k] = sr_q[(k+1)*TAP_CYC-1];
    end

    for (genvar c = 0; c < CH; c++) begin : g_ch
        dly_oneshot #(
            .PW_CYC (PW_CYC),
            .RETRIG (RETRIG)
        ) u_oneshot (
            .clk   (clk),
            .rst   (rst),
            .trig  (trig_s[c]),
            .pulse (pulse[c])
        );
    end

endmodule

// File: tb/tb_dly_line.sv
// Directed bench for dly_line: default, long-tap and two one-shot configurations.
module tb_dly_line;

`ifdef DLY_LINE_IN_SYNC_EN
    localparam int SL = 2;
`else
    localparam int SL = 0;
`endif

    logic        clk;
    logic        rst;
    logic        din0, din1, din2, din3;
    logic [1:0]  trig0, trig1, trig2, trig3;
    logic [10:0] taps0;
    logic [3:0]  taps1;
    logic [10:0] taps2, taps3;
    logic [1:0]  pulse0, pulse1, pulse2, pulse3;

    int total = 0;
    int bad   = 0;

    dly_line u_dut0 (
        .clk(clk), .rst(rst), .din(din0), .taps(taps0), .trig(trig0), .pulse(pulse0)
    );

    dly_line #(.TAPS(4), .TAP_CYC(3)) u_dut1 (
        .clk(clk), .rst(rst), .din(din1), .taps(taps1), .trig(trig1), .pulse(pulse1)
    );

    dly_line #(.PW_CYC(4), .RETRIG(0)) u_dut2 (
        .clk(clk), .rst(rst), .din(din2), .taps(taps2), .trig(trig2), .pulse(pulse2)
    );

    dly_line #(.PW_CYC(4), .RETRIG(1)) u_dut3 (
        .clk(clk), .rst(rst), .din(din3), .taps(taps3), .trig(trig3), .pulse(pulse3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Default line: din low sampled at posedges 1..3 appears on tap k after posedges k+1..k+3.
    function automatic logic [10:0] exp_taps0(input int m);
        logic [10:0] e;
        for (int k = 0; k < 11; k++) e[k] = (m >= k + 1) && (m <= k + 3);
        return e;
    endfunction

    // TAP_CYC=3: a single low sample at posedge 1 reaches tap k after posedge 3*(k+1).
    function automatic logic [3:0] exp_taps1(input int m);
        logic [3:0] e;
        for (int k = 0; k < 4; k++) e[k] = (m == 3 * (k + 1));
        return e;
    endfunction

    initial begin
        rst   = 1'b1;
        din0  = 1'b0;
        trig0 = 2'b00;
        din1  = 1'b1;
        din2  = 1'b1;
        din3  = 1'b1;
        trig1 = 2'b11;
        trig2 = 2'b11;
        trig3 = 2'b11;

        // Reset with din and trig low.
        repeat (3) step();
        chk("rst_taps", 32'(taps0), 32'd0);
        chk("rst_pulse", 32'(pulse0), 32'd0);
        chk("rst_pulse2", 32'(pulse2), 32'd0);
        rst  = 1'b0;
        din0 = 1'b1;
        #1;
        chk("rel_taps", 32'(taps0), 32'd0);
        chk("rel_pulse", 32'(pulse0), 32'd0);
        for (int i = 1; i <= 6; i++) begin
            step();
`ifndef DLY_LINE_IN_SYNC_EN
            chk("no_fire_held_low", 32'(pulse0), 32'd0);
`endif
        end

        // Genuine 1->0 on both channels at once.
        trig0 = 2'b11;
        repeat (3 + SL) step();
        trig0 = 2'b00;
        for (int n = 1; n <= 5 + SL; n++) begin
            step();
            chk("pulse_both", 32'(pulse0), (n - SL >= 1 && n - SL <= 2) ? 32'd3 : 32'd0);
        end
        trig0 = 2'b11;
        repeat (3 + SL) step();

        // Default delay line: 3-clock din low.
        din0 = 1'b0;
        for (int n = 1; n <= 16 + SL; n++) begin
            step();
            chk("taps_default", 32'(taps0), 32'(exp_taps0(n - SL)));
            if (n == 3) din0 = 1'b1;
        end

        // TAPS=4, TAP_CYC=3: 1-clock din low.
        din1 = 1'b0;
        for (int n = 1; n <= 15 + SL; n++) begin
            step();
            chk("taps_long", 32'(taps1), 32'(exp_taps1(n - SL)));
            chk("pulse1_idle", 32'(pulse1), 32'd0);
            if (n == 1) din1 = 1'b1;
        end

        // Second edge 2 clocks after the first: dropped (RETRIG=0), extends (RETRIG=1).
        trig2 = 2'b10;
        trig3 = 2'b10;
        for (int n = 1; n <= 9 + SL; n++) begin
            step();
            chk("nonretrig_ign", 32'(pulse2), (n - SL >= 1 && n - SL <= 4) ? 32'd1 : 32'd0);
            chk("retrig_ext", 32'(pulse3), (n - SL >= 1 && n - SL <= 6) ? 32'd1 : 32'd0);
            if (n == 1) begin
                trig2 = 2'b11;
                trig3 = 2'b11;
            end
            if (n == 2) begin
                trig2 = 2'b10;
                trig3 = 2'b10;
            end
        end
        trig2 = 2'b11;
        trig3 = 2'b11;
        repeat (6 + SL) step();

        // Edge on the final pulse cycle of a non-retriggerable channel.
        trig2 = 2'b10;
        for (int n = 1; n <= 11 + SL; n++) begin
            step();
            chk("nonretrig_last", 32'(pulse2), (n - SL >= 1 && n - SL <= 8) ? 32'd1 : 32'd0);
            if (n == 1) trig2 = 2'b11;
            if (n == 4) trig2 = 2'b10;
        end
        trig2 = 2'b11;
        repeat (6 + SL) step();

        // Reset mid-pulse and mid-propagation.
        din0  = 1'b0;
        trig0 = 2'b00;
        for (int n = 1; n <= 1 + SL; n++) begin
            step();
            din0 = 1'b1;
        end
        chk("pre_rst_pulse", 32'(pulse0), 32'd3);
        chk("pre_rst_taps", 32'(taps0), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_pulse", 32'(pulse0), 32'd0);
        chk("mid_rst_taps", 32'(taps0), 32'd0);
        trig0 = 2'b11;
        repeat (2) step();
        rst = 1'b0;
        repeat (14 + SL) step();
        chk("post_rst_taps", 32'(taps0), 32'd0);
        chk("post_rst_pulse", 32'(pulse0), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
